// File: rtl/record_sender_pkg.sv
// Types and constants shared by the record write controller and the record sender.
package record_sender_pkg;

  localparam int unsigned DEFAULT_BYTES_PER_RECORD = 16;
  localparam int unsigned COUNT_W                  = 16;
  localparam int unsigned BYTE_W                   = 8;
  localparam logic [BYTE_W-1:0] TERMINATOR         = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    TERM,
    DONE
  } state_e;

endpackage

// File: rtl/record_sender_if.sv
// Control, memory read port and transmit handshake of the record sender.
interface record_sender_if
  import record_sender_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic               start;
  logic [COUNT_W-1:0] numRecords;
  logic               memRen;
  logic [ADDR_W-1:0]  memAddr;
  logic [BYTE_W-1:0]  memData;
  logic [BYTE_W-1:0]  txByte;
  logic               txValid;
  logic               txReady;
  logic               busy;
  logic               done;

  modport master (
    input  start, numRecords, memData, txReady,
    output memRen, memAddr, txByte, txValid, busy, done
  );

  modport slave (
    output start, numRecords, memData, txReady,
    input  memRen, memAddr, txByte, txValid, busy, done
  );

endinterface

// File: rtl/record_sender.sv
// Streams numRecords fixed-size records from the result memory to the byte
// transmitter one byte at a time, then sends a single terminator byte.
module record_sender
  import record_sender_pkg::*;
#(
  parameter int unsigned BYTES_PER_RECORD = DEFAULT_BYTES_PER_RECORD,
  parameter int unsigned ADDR_W           = 16
) (
  input logic            clk,
  input logic            reset,
  record_sender_if.master bus
);

  localparam int unsigned BIDX_W = (BYTES_PER_RECORD > 1) ? $clog2(BYTES_PER_RECORD) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_RECORD - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [COUNT_W-1:0] rec_idx_q, rec_idx_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic               mem_ren_q, mem_ren_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               xfer_c;

  // tx_valid_q is high exactly in SEND and TERM, so this is the transfer strobe
  assign xfer_c = tx_valid_q && bus.txReady;

  // Next-state, counters and registered output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    rec_idx_d  = rec_idx_q;
    num_d      = num_q;
    tx_byte_d  = tx_byte_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d     = '0;
          byte_idx_d = '0;
          rec_idx_d  = '0;
          num_d      = bus.numRecords;
          if (bus.numRecords == '0) begin
            state_d   = TERM;
            tx_byte_d = TERMINATOR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        tx_byte_d = bus.memData;
        state_d   = SEND;
      end
      SEND: begin
        if (xfer_c) begin
          addr_d = addr_q + ADDR_W'(1);
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            rec_idx_d  = rec_idx_q + COUNT_W'(1);
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
          if (rec_idx_d == num_q) begin
            state_d   = TERM;
            tx_byte_d = TERMINATOR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      TERM: begin
        if (xfer_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_ren_d  = (state_d == FETCH);
    tx_valid_d = (state_d == SEND) || (state_d == TERM);
    busy_d     = (state_d == FETCH) || (state_d == WAIT) ||
                 (state_d == SEND)  || (state_d == TERM);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_idx_q <= '0;
      rec_idx_q  <= '0;
      num_q      <= '0;
      tx_byte_q  <= '0;
      mem_ren_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      rec_idx_q  <= rec_idx_d;
      num_q      <= num_d;
      tx_byte_q  <= tx_byte_d;
      mem_ren_q  <= mem_ren_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.memRen  = mem_ren_q;
  assign bus.memAddr = addr_q;
  assign bus.txByte  = tx_byte_q;
  assign bus.txValid = tx_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_record_sender.sv
// Self-checking bench for record_sender: transfer-level model plus directed pins.
module tb_record_sender;
  import record_sender_pkg::*;

  localparam int unsigned B = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  record_sender_if #(.ADDR_W(16)) bus ();
  record_sender_if #(.ADDR_W(4))  bus4 ();

  record_sender #(.BYTES_PER_RECORD(B), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
  record_sender #(.BYTES_PER_RECORD(B), .ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.master));

  logic [7:0] mem  [65536];
  logic [7:0] mem4 [16];

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;

  // stimulus controls
  bit          drv_reset, drv_start, drv_start4;
  logic [15:0] drv_num;
  int          ready_mode;  // 0 high, 1 toggle, 2 random, 3 low
  bit          tog;

  // transfer-level model of the expected outputs for the next cycle
  bit          m_active, m_term, chk_zero;
  bit          exp_ren, exp_valid, exp_busy, exp_done;
  logic [7:0]  exp_byte;
  logic [15:0] m_addr;
  int          m_total, m_sent, m_pending;
  bit          prev_stall;
  logic [7:0]  prev_dut_byte;

  // memory response pipes and logs
  bit          prev_ren, prev4_ren;
  logic [15:0] prev_addr;
  logic [3:0]  prev4_addr;
  logic [7:0]  tx_log[$], tx4_log[$];
  logic [15:0] ren_log[$];
  logic [3:0]  ren4_log[$];
  int          start_cyc, done_cyc, first_ren_cyc, first_val_cyc;
  bit          done4_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete(); tx4_log.delete(); ren_log.delete(); ren4_log.delete();
    done_cyc = -1; first_ren_cyc = -1; first_val_cyc = -1; done4_seen = 0;
  endtask

  task automatic step();
    bit xfer, n_ren, n_valid, n_done;
    @(negedge clk);
    cyc++;
    // compare this cycle against the model
    check("memRen",  32'(bus.memRen),  32'(exp_ren));
    check("txValid", 32'(bus.txValid), 32'(exp_valid));
    check("busy",    32'(bus.busy),    32'(exp_busy));
    check("done",    32'(bus.done),    32'(exp_done));
    check("memAddr", 32'(bus.memAddr), 32'(m_addr));
    if (exp_valid)  check("txByte", 32'(bus.txByte), 32'(exp_byte));
    if (chk_zero)   check("txByte_reset", 32'(bus.txByte), 32'h0);
    if (prev_stall) check("stall_hold", 32'(bus.txByte), 32'(prev_dut_byte));
    if (bus.memRen) begin
      ren_log.push_back(bus.memAddr);
      if (first_ren_cyc < 0) first_ren_cyc = cyc;
    end
    if (bus.txValid && first_val_cyc < 0) first_val_cyc = cyc;
    if (bus.done && done_cyc < 0) done_cyc = cyc;
    if (bus4.memRen) ren4_log.push_back(bus4.memAddr);
    if (bus4.txValid && bus4.txReady) tx4_log.push_back(bus4.txByte);
    if (bus4.done) done4_seen = 1;

    // drive inputs for the coming edge
    reset          = drv_reset;
    bus.start      = drv_start;
    bus.numRecords = drv_num;
    tog            = ~tog;
    case (ready_mode)
      0: bus.txReady = 1'b1;
      1: bus.txReady = tog;
      2: bus.txReady = ($urandom % 4) != 0;
      default: bus.txReady = 1'b0;
    endcase
    bus.memData  = prev_ren ? mem[prev_addr] : 8'($urandom);
    prev_ren     = bus.memRen;
    prev_addr    = bus.memAddr;
    bus4.start      = drv_start4;
    bus4.numRecords = 16'd2;
    bus4.txReady    = 1'b1;
    bus4.memData    = prev4_ren ? mem4[prev4_addr] : 8'($urandom);
    prev4_ren       = bus4.memRen;
    prev4_addr      = bus4.memAddr;

    xfer = exp_valid && bus.txReady;
    if (xfer) tx_log.push_back(bus.txByte);
    prev_stall    = exp_valid && !bus.txReady;
    prev_dut_byte = bus.txByte;

    // advance the model across the coming edge
    chk_zero = 0;
    if (drv_reset) begin
      m_active = 0; m_term = 0; m_pending = 0; m_addr = '0;
      exp_ren = 0; exp_valid = 0; exp_busy = 0; exp_done = 0;
      chk_zero = 1; prev_stall = 0;
    end else begin
      n_ren = 0; n_valid = exp_valid; n_done = 0;
      if (exp_done) begin
        m_active = 0;
      end else if (!m_active && drv_start) begin
        m_active = 1; m_sent = 0; m_addr = '0; m_pending = 0;
        m_total  = int'(drv_num) * B;
        m_term   = (m_total == 0);
        if (m_term) begin n_valid = 1; exp_byte = TERMINATOR; end
        else n_ren = 1;
      end
      if (exp_ren) m_pending = 1;
      else if (m_pending == 1) begin
        m_pending = 0; n_valid = 1; exp_byte = mem[m_addr];
      end
      if (xfer) begin
        n_valid = 0;
        if (m_term) n_done = 1;
        else begin
          m_sent++; m_addr = m_addr + 16'd1;
          if (m_sent == m_total) begin m_term = 1; n_valid = 1; exp_byte = TERMINATOR; end
          else n_ren = 1;
        end
      end
      exp_ren = n_ren; exp_valid = n_valid; exp_done = n_done;
      exp_busy = m_active && !n_done;
    end
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    drv_start = 0;
    while (m_active && n < max) begin step(); n++; end
    if (m_active) check("timeout", 32'h1, 32'h0);
    step();
  endtask

  task automatic kick(input logic [15:0] num);
    clear_logs();
    drv_num = num; drv_start = 1;
    step();
    start_cyc = cyc;
    drv_start = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    mem[20] = 8'h00; mem[40] = 8'h00;
    for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
    mem4[5] = 8'h00;

    reset = 1'b1; bus.start = 1'b0; bus.numRecords = '0; bus.txReady = 1'b0; bus.memData = '0;
    bus4.start = 1'b0; bus4.numRecords = '0; bus4.txReady = 1'b0; bus4.memData = '0;
    drv_reset = 1; drv_start = 0; drv_start4 = 0; drv_num = '0; ready_mode = 0; tog = 0;
    m_addr = '0; exp_byte = '0; chk_zero = 1;
    clear_logs();
    step(); step();
    drv_reset = 0;
    step();

    // one record of 0x01..0x10, receiver always ready
    ready_mode = 0;
    kick(16'd1);
    run_idle(200);
    check("t1_count", 32'(tx_log.size()), 32'd17);
    for (int i = 0; i < 17 && i < tx_log.size(); i++)
      check("t1_byte", 32'(tx_log[i]), (i == 16) ? 32'h0 : 32'(i + 1));
    check("t1_done_lat", 32'(done_cyc - start_cyc), 32'd50);
    check("t1_ren_lat",  32'(first_ren_cyc - start_cyc), 32'd1);
    check("t1_val_lat",  32'(first_val_cyc - start_cyc), 32'd3);
    check("t1_reads", 32'(ren_log.size()), 32'd16);
    for (int i = 0; i < ren_log.size(); i++) check("t1_addr", 32'(ren_log[i]), 32'(i));

    // zero records: terminator only
    kick(16'd0);
    run_idle(50);
    check("t2_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("t2_byte", 32'(tx_log[0]), 32'h0);
    check("t2_reads", 32'(ren_log.size()), 32'd0);
    check("t2_done_lat", 32'(done_cyc - start_cyc), 32'd2);

    // two records, ready toggling every cycle
    ready_mode = 1;
    kick(16'd2);
    run_idle(400);
    check("t3_count", 32'(tx_log.size()), 32'd33);
    check("t3_reads", 32'(ren_log.size()), 32'd32);
    if (tx_log.size() == 33) begin
      check("t3_first", 32'(tx_log[0]), 32'h01);
      check("t3_zero_inside", 32'(tx_log[20]), 32'h00);
      check("t3_last", 32'(tx_log[32]), 32'h00);
    end

    // start pulses while busy are ignored
    ready_mode = 0;
    kick(16'd1);
    drv_num = 16'd3;
    for (int i = 0; i < 30; i++) begin drv_start = (i % 3) == 0; step(); end
    run_idle(200);
    check("t4_count", 32'(tx_log.size()), 32'd17);
    check("t4_reads", 32'(ren_log.size()), 32'd16);

    // reset while a byte is being offered
    ready_mode = 3;
    kick(16'd1);
    for (int i = 0; i < 10 && !exp_valid; i++) step();
    step();
    drv_reset = 1; step();
    drv_reset = 0; step();
    check("t5_no_done", 32'(done_cyc), 32'hffff_ffff);
    ready_mode = 0;
    kick(16'd1);
    run_idle(200);
    if (ren_log.size() > 0) check("t5_restart_addr", 32'(ren_log[0]), 32'h0);
    check("t5_count", 32'(tx_log.size()), 32'd17);

    // 4-bit address counter wraps into the second record
    clear_logs();
    drv_start4 = 1; step(); drv_start4 = 0;
    for (int i = 0; i < 150 && !done4_seen; i++) step();
    check("t6_done", 32'(done4_seen), 32'h1);
    check("t6_count", 32'(tx4_log.size()), 32'd33);
    check("t6_reads", 32'(ren4_log.size()), 32'd32);
    for (int i = 0; i < tx4_log.size(); i++)
      check("t6_byte", 32'(tx4_log[i]), (i >= 32) ? 32'h0 : 32'(mem4[i % 16]));
    for (int i = 0; i < ren4_log.size(); i++)
      check("t6_addr", 32'(ren4_log[i]), 32'(i % 16));

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ready_mode = (i % 500 < 250) ? 2 : 0;
      drv_start  = ($urandom % 8) == 0;
      drv_num    = 16'($urandom_range(0, 3));
      drv_reset  = ($urandom % 400) == 0;
      step();
    end
    drv_reset = 0;
    ready_mode = 0;
    run_idle(400);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
